// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM state encoding and
// SPI mode constants packed as {cpol, cpha}.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clkgen.sv
// SCLK timing: H-cycle down-counter producing an edge_tick strobe every
// div+1 clocks, plus a count of SCLK edges produced since the last load.
module spi_clkgen #(
  parameter int DIV_W = 8,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             edge_tick,
  output logic [IDX_W-1:0] edge_idx
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Counting from div down to zero spans div+1 cycles, so all-ones never wraps early
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    edge_tick = 1'b0;
    if (load) begin
      cnt_d = div;
      div_d = div;
      idx_d = '0;
    end else if (en) begin
      if (cnt_q == '0) begin
        edge_tick = 1'b1;
        cnt_d     = div_q;
        idx_d     = idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  assign edge_idx = idx_q;

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master with run-time mode, SCLK divider, bit order,
// multiple chip-selects with optional hold across bursts, busy/done handshake.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 2,
  parameter int CS_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clkdiv,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              keep_cs,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              spi_clk,
  output logic              spi_di,
  input  logic              spi_do,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int IDX_W = $clog2(2*DATA_W + 2);
  localparam logic [IDX_W-1:0] LAST_EDGE = IDX_W'(2*DATA_W);

  spi_state_e state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic spi_clk_q, spi_clk_d;
  logic spi_di_q, spi_di_d;
  logic done_q, done_d;
  logic cpha_q, cpha_d;
  logic lsb_q, lsb_d;
  logic keep_q, keep_d;

  logic              load;
  logic              edge_tick;
  logic [IDX_W-1:0]  edge_idx;
  logic [IDX_W-1:0]  edge_num;
  logic [DATA_W-1:0] tx_w;
  logic              sample_edge;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  spi_clkgen #(
    .DIV_W(DIV_W),
    .IDX_W(IDX_W)
  ) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (state_q != ST_IDLE),
    .div      (clkdiv),
    .edge_tick(edge_tick),
    .edge_idx (edge_idx)
  );

  // The transmit word is pre-reversed for LSB-first so the shifter always emits its MSB
  assign tx_w        = lsb_first ? bit_rev(din) : din;
  assign edge_num    = edge_idx + IDX_W'(1);
  assign sample_edge = edge_num[0] ^ cpha_q;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    cs_n_d    = cs_n_q;
    spi_clk_d = spi_clk_q;
    spi_di_d  = spi_di_q;
    done_d    = 1'b0;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    keep_d    = keep_q;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_d   = ST_SETUP;
          cpha_d    = cpha;
          lsb_d     = lsb_first;
          keep_d    = keep_cs;
          spi_clk_d = cpol;
          rx_d      = '0;
          for (int i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = (cs_sel != CS_W'(i));
          end
          if (!cpha) begin
            spi_di_d = tx_w[DATA_W-1];
            tx_d     = tx_w << 1;
          end else begin
            tx_d = tx_w;
          end
        end
      end

      ST_SETUP, ST_SHIFT: begin
        if (edge_tick) begin
          spi_clk_d = ~spi_clk_q;
          if (sample_edge) begin
            rx_d = {rx_q[DATA_W-2:0], spi_do};
          end else if (edge_num != LAST_EDGE) begin
            spi_di_d = tx_q[DATA_W-1];
            tx_d     = tx_q << 1;
          end
          state_d = (edge_num == LAST_EDGE) ? ST_HOLD : ST_SHIFT;
        end
      end

      ST_HOLD: begin
        if (edge_tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          dout_d  = lsb_q ? bit_rev(rx_q) : rx_q;
          if (!keep_q) begin
            cs_n_d = '1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      cs_n_q    <= '1;
      spi_clk_q <= 1'b0;
      spi_di_q  <= 1'b0;
      done_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      keep_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      cs_n_q    <= cs_n_d;
      spi_clk_q <= spi_clk_d;
      spi_di_q  <= spi_di_d;
      done_q    <= done_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      keep_q    <= keep_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign dout    = dout_q;
  assign cs_n    = cs_n_q;
  assign spi_clk = spi_clk_q;
  assign spi_di  = spi_di_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: a behavioural SPI slave answers each
// transfer; a monitor checks dout, captured MOSI, done timing and chip-selects.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int DW   = 8;
  localparam int DIVW = 8;
  localparam int NCS  = 3;
  localparam int CSW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DW-1:0]   din;
  logic            cpol, cpha, lsb_first, keep_cs;
  logic [DIVW-1:0] clkdiv;
  logic [CSW-1:0]  cs_sel;
  logic [DW-1:0]   dout;
  logic            busy, done, spi_clk, spi_di;
  logic            spi_do = 1'b0;
  logic [NCS-1:0]  cs_n;

  always #5 clk = ~clk;

  spi_master_param #(
    .DATA_W(DW),
    .DIV_W (DIVW),
    .NUM_CS(NCS),
    .CS_W  (CSW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din      (din),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsb_first(lsb_first),
    .clkdiv   (clkdiv),
    .cs_sel   (cs_sel),
    .keep_cs  (keep_cs),
    .dout     (dout),
    .busy     (busy),
    .done     (done),
    .spi_clk  (spi_clk),
    .spi_di   (spi_di),
    .spi_do   (spi_do),
    .cs_n     (cs_n)
  );

  typedef struct {
    logic [DW-1:0] mosi_word;
    logic [DW-1:0] miso_word;
    longint        exp_cycle;
    logic          keep;
  } exp_t;

  typedef struct {
    int   sel;
    logic pol;
  } acc_t;

  exp_t   scoreboard[$];
  acc_t   acc_q[$];
  int     total = 0;
  int     bad = 0;
  longint cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural slave: counts SCLK edges of the current word, drives MISO and captures MOSI
  logic          s_cpha, s_lsb, s_active;
  logic [DW-1:0] s_tx, s_rx;
  int            s_edges, s_txn, s_rxn;
  int            slave_go = 0, slave_seen = 0, slave_cmd = 0;

  function automatic int bitpos(input int n, input logic lsb);
    return lsb ? n : DW - 1 - n;
  endfunction

  always @(spi_clk or slave_go) begin
    if (slave_go != slave_seen) begin
      slave_seen = slave_go;
      if (slave_cmd == 1) begin
        s_active = 1'b1;
        s_edges  = 0;
        s_rxn    = 0;
        s_txn    = 0;
        s_rx     = '0;
        if (!s_cpha) begin
          spi_do = s_tx[bitpos(0, s_lsb)];
          s_txn  = 1;
        end
      end else begin
        s_active = 1'b0;
      end
    end else if (s_active) begin
      s_edges++;
      if (((s_edges % 2) == 1) != s_cpha) begin
        if (s_rxn < DW) begin
          s_rx[bitpos(s_rxn, s_lsb)] = spi_di;
          s_rxn++;
        end
      end else if (s_txn < DW) begin
        spi_do = s_tx[bitpos(s_txn, s_lsb)];
        s_txn++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Monitor: cs/idle-clock model updated from accept records, scoreboard popped on done
  int model_cs = -1;
  logic model_cpol = 1'b0;

  always @(negedge clk) begin
    logic [NCS-1:0] exp_cs;
    exp_t e;
    acc_t a;
    if (rst) begin
      scoreboard.delete();
      acc_q.delete();
      model_cs   = -1;
      model_cpol = 1'b0;
    end else begin
      while (acc_q.size() > 0) begin
        a          = acc_q.pop_front();
        model_cs   = a.sel;
        model_cpol = a.pol;
      end
      if (done) begin
        checkOutput("busy_in_done", 64'(busy), 64'd0);
        if (scoreboard.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = scoreboard.pop_front();
          checkOutput("dout", 64'(dout), 64'(e.miso_word));
          checkOutput("mosi", 64'(s_rx), 64'(e.mosi_word));
          checkOutput("done_cycle", 64'(cycle), 64'(e.exp_cycle));
          if (!e.keep) model_cs = -1;
        end
      end
      exp_cs = '1;
      if (model_cs >= 0 && model_cs < NCS) exp_cs[model_cs] = 1'b0;
      checkOutput("cs_n", 64'(cs_n), 64'(exp_cs));
      if (!busy) checkOutput("idle_sclk", 64'(spi_clk), 64'(model_cpol));
    end
  end

  // Called at a negedge; waits for busy=0 so consecutive calls run back-to-back
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [DW-1:0] sw,
                               input logic pol, input logic pha, input logic lsb,
                               input logic [DIVW-1:0] dv, input logic [CSW-1:0] sel,
                               input logic keep);
    int guard = 0;
    exp_t e;
    acc_t a;
    while (busy && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checkOutput("busy_timeout", 64'd1, 64'd0);
      return;
    end
    din       = d;
    cpol      = pol;
    cpha      = pha;
    lsb_first = lsb;
    clkdiv    = dv;
    cs_sel    = sel;
    keep_cs   = keep;
    start     = 1'b1;
    s_tx      = sw;
    s_cpha    = pha;
    s_lsb     = lsb;
    @(posedge clk);
    #1;
    slave_cmd = 1;
    slave_go++;
    a.sel = int'(sel);
    a.pol = pol;
    acc_q.push_back(a);
    e.mosi_word = d;
    e.miso_word = sw;
    e.exp_cycle = cycle + longint'((2*DW + 1) * (int'(dv) + 1));
    e.keep      = keep;
    scoreboard.push_back(e);
    @(negedge clk);
    start     = 1'b0;
    din       = DW'($urandom);
    cpol      = 1'($urandom);
    cpha      = 1'($urandom);
    lsb_first = 1'($urandom);
    clkdiv    = DIVW'($urandom);
    cs_sel    = CSW'($urandom);
    keep_cs   = 1'($urandom);
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; din = '0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; clkdiv = '0; cs_sel = '0; keep_cs = 1'b0;
    #1;
    checkOutput("rst_cs_n", 64'(cs_n), 64'(3'b111));
    checkOutput("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0, fastest clock, MSB first
    applyStimulus(8'hCB, 8'hCB, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    // Mode 3, clkdiv=2, slave returns B3
    applyStimulus(8'h5A, 8'hB3, 1'b1, 1'b1, 1'b0, 8'd2, 2'd0, 1'b0);
    // LSB first, mode 1, chip-select 1
    applyStimulus(8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 8'd0, 2'd1, 1'b0);
    // Burst with CS held, second word issued in the done cycle
    applyStimulus(8'h12, 8'hA5, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    applyStimulus(8'h34, 8'h3C, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    // Out-of-range chip-select
    applyStimulus(8'hE7, 8'h19, 1'b1, 1'b0, 1'b1, 8'd1, 2'd3, 1'b0);

    // Start pulsed while busy must be ignored
    applyStimulus(8'h6D, 8'hC2, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
    repeat (4) @(negedge clk);
    din = 8'h92; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Largest divider
    applyStimulus(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 8'hFF, 2'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [DIVW-1:0] dv;
      dv = ($urandom_range(0, 7) == 0) ? DIVW'($urandom_range(0, 20)) : DIVW'($urandom_range(0, 2));
      applyStimulus(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    dv, CSW'($urandom_range(0, 3)), 1'($urandom));
      repeat ($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 3)) @(negedge clk);
    end

    // Reset during SHIFT edge 5 (H=4, edge 5 at accept+20)
    applyStimulus(8'hAA, 8'h55, 1'b1, 1'b0, 1'b0, 8'd3, 2'd1, 1'b1);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_cs_n", 64'(cs_n), 64'(3'b111));
    checkOutput("midrst_sclk", 64'(spi_clk), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_dout", 64'(dout), 64'd0);
    slave_cmd = 2;
    slave_go++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'hC3, 8'h7E, 1'b0, 1'b1, 1'b0, 8'd1, 2'd2, 1'b0);

    guard = 0;
    while (scoreboard.size() > 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", 64'(scoreboard.size()), 64'd0);
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
